traffic_conflict_monitor: RTL and testbench

Independent safety monitor that observes the NS and EW light outputs of the traffic light controller and checks them against the signalling rules. Illegal encodings, conflicting right-of-way, illegal colour sequences, short yellow intervals and short all-red clearance intervals are all detected. The first violation is latched with a code, and the monitor drives a red-flash request until software clears it. It sits beside the controller and consumes the same 3-bit one-hot light buses: red=100, yellow=010, green=001.

---
 rtl/traffic_conflict_monitor.sv | 126 ++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the NS/EW light buses: flags illegal encodings, conflicts, bad sequences and short intervals.
// Latency: 1 cycle from violating sample to fault/fault_code/viol_count; no backpressure, observes every clk.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW  = 2,
    parameter int MIN_ALL_RED = 1,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] NS_light,
    input  logic [2:0] EW_light,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red,
    output logic [7:0] viol_count
);

    localparam logic [2:0]       RED     = 3'b100;
    localparam logic [2:0]       YEL     = 3'b010;
    localparam logic [2:0]       GRN     = 3'b001;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MIN_AR  = CNT_W'(MIN_ALL_RED);
    localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FLASH_HALF - 1);

    logic [2:0]       prev_ns, prev_ew;
    logic [CNT_W-1:0] y_ns, y_ew, ar_cnt, flash_cnt;

    logic       cur_ok, prev_ok, chk_ok;
    logic       c_enc, c_conf, c_seq, c_sy, c_sc;
    logic       viol;
    logic [2:0] vcode;
    logic       fault_nxt;
    logic [2:0] code_nxt;

    function automatic logic enc_ok(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    function automatic logic seq_bad(input logic [2:0] p, input logic [2:0] c);
        return (p != c) && !((p == GRN && c == YEL) ||
                             (p == YEL && c == RED) ||
                             (p == RED && c == GRN));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        cur_ok  = enc_ok(NS_light) && enc_ok(EW_light);
        prev_ok = enc_ok(prev_ns) && enc_ok(prev_ew);
        chk_ok  = cur_ok && prev_ok;

        c_enc  = !cur_ok;
        c_conf = (NS_light != RED) && (EW_light != RED);
        c_seq  = chk_ok && (seq_bad(prev_ns, NS_light) || seq_bad(prev_ew, EW_light));
        c_sy   = chk_ok && ((prev_ns == YEL && NS_light == RED && y_ns < MIN_Y) ||
                            (prev_ew == YEL && EW_light == RED && y_ew < MIN_Y));
        c_sc   = chk_ok && ((prev_ns == RED && NS_light == GRN) ||
                            (prev_ew == RED && EW_light == GRN)) && (ar_cnt < MIN_AR);

        viol  = c_enc || c_conf || c_seq || c_sy || c_sc;
        vcode = 3'd0;
        if (c_enc)       vcode = 3'd1;
        else if (c_conf) vcode = 3'd2;
        else if (c_seq)  vcode = 3'd3;
        else if (c_sy)   vcode = 3'd4;
        else if (c_sc)   vcode = 3'd5;

        // A violation always wins over a simultaneous clear request.
        fault_nxt = fault;
        code_nxt  = fault_code;
        if (viol && (!fault || clear_fault)) begin
            fault_nxt = 1'b1;
            code_nxt  = vcode;
        end else if (clear_fault) begin
            fault_nxt = 1'b0;
            code_nxt  = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ns    <= RED;
            prev_ew    <= RED;
            y_ns       <= '0;
            y_ew       <= '0;
            ar_cnt     <= '0;
            flash_cnt  <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash_red  <= 1'b0;
            viol_count <= 8'd0;
        end else begin
            prev_ns <= NS_light;
            prev_ew <= EW_light;
            // Counters track the sample that becomes prev_* after this edge.
            y_ns    <= (NS_light == YEL) ? sat_inc(y_ns) : '0;
            y_ew    <= (EW_light == YEL) ? sat_inc(y_ew) : '0;
            ar_cnt  <= (NS_light == RED && EW_light == RED) ? sat_inc(ar_cnt) : '0;

            fault      <= fault_nxt;
            fault_code <= code_nxt;

            if (viol && viol_count != 8'hFF)
                viol_count <= viol_count + 8'd1;

            if (!fault_nxt) begin
                flash_red <= 1'b0;
                flash_cnt <= '0;
            end else if (!fault) begin
                flash_red <= 1'b1;
                flash_cnt <= '0;
            end else if (flash_cnt >= FH_LAST) begin
                flash_red <= ~flash_red;
                flash_cnt <= '0;
            end else begin
                flash_cnt <= sat_inc(flash_cnt);
            end
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed vector bench for traffic_conflict_monitor: table of per-cycle expectations plus reset/saturation sequences.
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ns  = R;
    logic [2:0] ew  = R;
    logic       clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_red;
    logic [7:0] viol_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       clr;
        logic       f;
        logic [2:0] code;
        logic       fl;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    traffic_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .NS_light   (ns),
        .EW_light   (ew),
        .clear_fault(clr),
        .fault      (fault),
        .fault_code (fault_code),
        .flash_red  (flash_red),
        .viol_count (viol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic f, input logic [2:0] c,
                           input logic fl, input logic [7:0] n);
        chk({tag, ".fault"},      {7'd0, fault},      {7'd0, f});
        chk({tag, ".fault_code"}, {5'd0, fault_code}, {5'd0, c});
        chk({tag, ".flash_red"},  {7'd0, flash_red},  {7'd0, fl});
        chk({tag, ".viol_count"}, viol_count,         n);
    endtask

    task automatic add(input logic [2:0] a, input logic [2:0] b, input logic c,
                       input logic f, input logic [2:0] code, input logic fl, input logic [7:0] n);
        vec_t v;
        v.ns = a; v.ew = b; v.clr = c; v.f = f; v.code = code; v.fl = fl; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic c);
        ns  = a;
        ew  = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Legal full cycle
        for (int i = 0; i < 3; i++) add(R, R, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(G, R, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(Y, R, 0, 0, 0, 0, 0);
        add(R, R, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(R, G, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(R, Y, 0, 0, 0, 0, 0);
        add(R, R, 0, 0, 0, 0, 0);
        // Conflict, then flash cadence
        for (int i = 0; i < 3; i++) add(R, R, 0, 0, 0, 0, 0);
        add(G, G, 0, 1, 2, 1, 1);
        add(Y, Y, 0, 1, 2, 1, 2);
        add(R, R, 0, 1, 2, 1, 3);
        add(R, R, 0, 1, 2, 1, 3);
        for (int i = 0; i < 4; i++) add(R, R, 0, 1, 2, 0, 3);
        add(R, R, 0, 1, 2, 1, 3);
        add(R, R, 1, 0, 0, 0, 3);
        // Encoding beats conflict
        add(3'b011, G, 0, 1, 1, 1, 4);
        add(R, R, 0, 1, 1, 1, 4);
        add(R, R, 1, 0, 0, 0, 4);
        // Short yellow, later violation keeps first code
        for (int i = 0; i < 3; i++) add(G, R, 0, 0, 0, 0, 4);
        add(Y, R, 0, 0, 0, 0, 4);
        add(R, R, 0, 1, 4, 1, 5);
        add(G, R, 0, 1, 4, 1, 5);
        add(R, R, 0, 1, 4, 1, 6);
        // Sequence, clear, clear-vs-conflict
        add(R, R, 1, 0, 0, 0, 6);
        add(G, R, 0, 0, 0, 0, 6);
        add(R, R, 0, 1, 3, 1, 7);
        add(R, R, 1, 0, 0, 0, 7);
        add(G, R, 0, 0, 0, 0, 7);
        add(R, R, 0, 1, 3, 1, 8);
        add(G, G, 1, 1, 2, 1, 9);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ns, vecs[i].ew, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].f, vecs[i].code, vecs[i].fl, vecs[i].cnt);
        end

        // Held conflict saturates the violation counter
        for (int i = 0; i < 300; i++) step(G, G, 0);
        chk("sat.viol_count", viol_count, 8'd255);
        chk("sat.fault_code", {5'd0, fault_code}, 8'd2);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        ns  = R;
        ew  = R;

        // Green straight out of reset is a short clearance
        step(G, R, 0);
        chk_all("post_rst_green", 1, 5, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
